countdown_timer: RTL and testbench

//   Receiving end of the keypad timer entry. Captures the three BCD digits (M:S S)

---
 rtl/countdown_timer.sv | 162 ++++++++++++++++
 tb/tb_countdown_timer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: captures an M:SS BCD time from the keypad entry block and
// counts it down once per second while the oven runs. Reports run/done status
// to the magnetron control and the live digits to the display.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | digits loaded or cleared, waiting for start
//   RUN   | counting down, magnetron enabled
//   PAUSE | countdown frozen, prescaler and digits held
//   DONE  | reached 0:00 from RUN, waiting for stop or a new load
module countdown_timer #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic       clk,
   input  logic       clearn,
   input  logic       load_n,
   input  logic [3:0] min_in,
   input  logic [3:0] tens_in,
   input  logic [3:0] units_in,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] min_out,
   output logic [3:0] tens_out,
   output logic [3:0] units_out,
   output logic       running,
   output logic       zero,
   output logic       done
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    min_q, min_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    units_q, units_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          running_q;
   logic          done_q, done_d;

   logic [3:0]    dec_min, dec_tens, dec_units;
   logic          dec_zero;

   // Out-of-range entry digits are clamped so the display never shows non-BCD.
   function automatic logic [3:0] sat9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // One-second decrement of the M:SS value; tens above 5 count down normally.
   always_comb begin
      dec_min   = min_q;
      dec_tens  = tens_q;
      dec_units = units_q;
      if (units_q != 4'd0) begin
         dec_units = units_q - 4'd1;
      end else begin
         dec_units = 4'd9;
         if (tens_q != 4'd0) begin
            dec_tens = tens_q - 4'd1;
         end else begin
            dec_tens = 4'd5;
            dec_min  = min_q - 4'd1;
         end
      end
      dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_units == 4'd0);
   end

   assign zero = (min_q == 4'd0) && (tens_q == 4'd0) && (units_q == 4'd0);

   // Next-state, digit and prescaler logic; priority load_n > stop > start.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      tens_d  = tens_q;
      units_d = units_q;
      presc_d = presc_q;
      done_d  = 1'b0;

      case (state_q)
         RUN: begin
            if (stop) begin
               state_d = PAUSE;
            end else if (zero) begin
               // Unreachable in normal flow; never count below 0:00.
               state_d = DONE;
            end else if (presc_q == PRESC_TC) begin
               presc_d = '0;
               min_d   = dec_min;
               tens_d  = dec_tens;
               units_d = dec_units;
               if (dec_zero) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: begin
            if (!load_n) begin
               state_d = IDLE;
               min_d   = sat9(min_in);
               tens_d  = sat9(tens_in);
               units_d = sat9(units_in);
               presc_d = '0;
            end else if (stop) begin
               if (state_q == PAUSE) begin
                  state_d = IDLE;
                  min_d   = 4'd0;
                  tens_d  = 4'd0;
                  units_d = 4'd0;
                  presc_d = '0;
               end else if (state_q == DONE) begin
                  state_d = IDLE;
               end
            end else if (start) begin
               if (state_q == IDLE && !zero) begin
                  state_d = RUN;
                  presc_d = '0;
               end else if (state_q == PAUSE) begin
                  state_d = RUN;
               end
            end
         end
      endcase
   end

   // State, digit and status registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!clearn) begin
         state_q   <= IDLE;
         min_q     <= 4'd0;
         tens_q    <= 4'd0;
         units_q   <= 4'd0;
         presc_q   <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         tens_q    <= tens_d;
         units_q   <= units_d;
         presc_q   <= presc_d;
         running_q <= (state_d == RUN);
         done_q    <= done_d;
      end
   end

   assign min_out   = min_q;
   assign tens_out  = tens_q;
   assign units_out = units_q;
   assign running   = running_q;
   assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a 4-cycle second.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       clearn = 1'b0;
   logic       load_n = 1'b1;
   logic [3:0] min_in = 4'd0, tens_in = 4'd0, units_in = 4'd0;
   logic       start = 1'b0, stop = 1'b0;
   logic [3:0] min_out, tens_out, units_out;
   logic       running, zero, done;

   int checks = 0;
   int failures = 0;
   int done_pulses = 0;

   countdown_timer #(.TICKS_PER_SEC(4)) dut (
      .clk(clk), .clearn(clearn), .load_n(load_n),
      .min_in(min_in), .tens_in(tens_in), .units_in(units_in),
      .start(start), .stop(stop),
      .min_out(min_out), .tens_out(tens_out), .units_out(units_out),
      .running(running), .zero(zero), .done(done)
   );

   always #5 clk = ~clk;

   // Count done-high cycles, sampled mid-cycle.
   always @(negedge clk) if (done) done_pulses++;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int digits();
      return int'({min_out, tens_out, units_out});
   endfunction

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] u);
      load_n = 1'b0; min_in = m; tens_in = t; units_in = u;
      steps(1);
      load_n = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1; steps(1); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; steps(1); stop = 1'b0;
   endtask

   initial begin
      // Reset
      steps(2);
      check("rst_digits", digits(), 'h000);
      check("rst_running", running, 0);
      check("rst_done", done, 0);
      check("rst_zero", zero, 1);
      clearn = 1'b1;

      // 0:12 full run to DONE
      load(4'd0, 4'd1, 4'd2);
      check("load012", digits(), 'h012);
      check("load012_run", running, 0);
      pulse_start();
      check("run012_running", running, 1);
      steps(3);
      check("run012_c3", digits(), 'h012);
      steps(1);
      check("run012_c4", digits(), 'h011);
      steps(4);
      check("run012_c8", digits(), 'h010);
      steps(39);
      check("run012_c47", digits(), 'h001);
      check("run012_c47_done", done, 0);
      check("run012_c47_running", running, 1);
      steps(1);
      check("run012_c48", digits(), 'h000);
      check("run012_done", done, 1);
      check("run012_c48_running", running, 0);
      check("run012_zero", zero, 1);
      steps(1);
      check("done_one_cycle", done, 0);

      // DONE ignores start; stop returns to IDLE
      pulse_start();
      check("done_start_ign", running, 0);
      check("done_start_digits", digits(), 'h000);
      pulse_stop();
      check("done_stop_idle", running, 0);
      pulse_start();
      check("idle_zero_start", running, 0);

      // 1:00 -> 0:59 borrow
      load(4'd1, 4'd0, 4'd0);
      pulse_start();
      steps(3);
      check("run100_c3", digits(), 'h100);
      steps(1);
      check("run100_c4", digits(), 'h059);
      pulse_stop();
      pulse_stop();
      check("clr_after_100", digits(), 'h000);

      // 0:90 counts down through tens above 5; load ignored in RUN
      load(4'd0, 4'd9, 4'd0);
      check("load090", digits(), 'h090);
      pulse_start();
      steps(4);
      check("run090_c4", digits(), 'h089);
      load(4'd3, 4'd3, 4'd3);
      check("run_load_ign", digits(), 'h089);
      check("run_load_running", running, 1);
      steps(35);
      check("run090_c40", digits(), 'h080);
      steps(4);
      check("run090_c44", digits(), 'h079);
      pulse_stop();
      pulse_stop();

      // Pause / resume with held prescaler
      load(4'd0, 4'd0, 4'd5);
      pulse_start();
      steps(6);
      check("run005_c6", digits(), 'h004);
      pulse_stop();
      check("pause_running", running, 0);
      steps(5);
      check("pause_hold", digits(), 'h004);
      pulse_start();
      check("resume_running", running, 1);
      steps(1);
      check("resume_c1", digits(), 'h004);
      steps(1);
      check("resume_c2", digits(), 'h003);
      // Stop on the tick edge suppresses the decrement
      steps(3);
      pulse_stop();
      check("stop_beats_tick", digits(), 'h003);
      pulse_start();
      steps(1);
      check("resume_at_tc", digits(), 'h002);

      // start and stop together: stop wins
      start = 1'b1; stop = 1'b1;
      steps(1);
      check("both_pause", running, 0);
      check("both_pause_digits", digits(), 'h002);
      steps(1);
      start = 1'b0; stop = 1'b0;
      check("both_clear", digits(), 'h000);
      check("both_clear_zero", zero, 1);
      pulse_start();
      check("idle_zero_start2", running, 0);

      // Saturating load of non-BCD digits
      load(4'hA, 4'hF, 4'hC);
      check("sat_load", digits(), 'h999);

      // Reset mid-RUN
      load(4'd0, 4'd0, 4'd3);
      pulse_start();
      check("pre_rst_running", running, 1);
      clearn = 1'b0;
      steps(1);
      clearn = 1'b1;
      check("mid_rst_digits", digits(), 'h000);
      check("mid_rst_running", running, 0);
      check("mid_rst_done", done, 0);
      steps(8);
      check("mid_rst_idle", running, 0);
      check("done_pulse_total", done_pulses, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
